light_sched: RTL

//  Scheduler and sequencer for the 16-bit running-light LED bank on the NVBoard.
//  A programmable prescaler generates advance ticks; on each tick a pattern engine steps the LED

---
 rtl/light_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/light_sched.sv
// Running-light scheduler for a 16-bit LED bank: a prescaler generates advance ticks,
// a pattern engine steps the LEDs, and a button-driven run/pause FSM gates the prescaler.
module light_sched #(
    parameter int unsigned BASE_DIV = 5000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [2:0]  speed,
    input  logic        btn_pause,
    input  logic        btn_step,
    output logic [15:0] led,
    output logic        tick,
    output logic        running
);

    typedef enum logic {ST_RUN, ST_PAUSED} state_t;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

    state_t             r_state;
    dir_t               r_dir;
    logic [1:0]         r_mode_q;
    logic [CNT_W-1:0]   r_count;
    logic               r_pause_s1, r_pause_s2, r_pause_prev;
    logic               r_step_s1, r_step_s2, r_step_prev;

    logic               w_pause_edge, w_step_edge, w_step;
    logic               w_cnt_adv, w_adv;
    logic [CNT_W-1:0]   w_period;
    logic               w_onehot;
    logic [15:0]        w_bnc_led;
    dir_t               w_bnc_dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pause_s1   <= 1'b0;
            r_pause_s2   <= 1'b0;
            r_pause_prev <= 1'b0;
            r_step_s1    <= 1'b0;
            r_step_s2    <= 1'b0;
            r_step_prev  <= 1'b0;
        end else begin
            r_pause_s1   <= btn_pause;
            r_pause_s2   <= r_pause_s1;
            r_pause_prev <= r_pause_s2;
            r_step_s1    <= btn_step;
            r_step_s2    <= r_step_s1;
            r_step_prev  <= r_step_s2;
        end
    end

    assign w_pause_edge = r_pause_s2 & ~r_pause_prev;
    assign w_step_edge  = r_step_s2 & ~r_step_prev;
    // A pause edge in the same cycle swallows a step edge.
    assign w_step       = (r_state == ST_PAUSED) && w_step_edge && !w_pause_edge;
    assign w_period     = CNT_W'(BASE_DIV) << speed;
    assign w_cnt_adv    = (r_state == ST_RUN) && (r_count >= w_period - CNT_W'(1));
    assign w_adv        = w_cnt_adv | w_step;

    always_comb begin
        w_onehot  = (led != '0) && ((led & (led - 16'd1)) == '0);
        w_bnc_led = 16'h0001;
        w_bnc_dir = r_dir;
        if (w_onehot) begin
            if (r_dir == DIR_LEFT) begin
                if (led == 16'h8000) begin
                    w_bnc_led = 16'h4000;
                    w_bnc_dir = DIR_RIGHT;
                end else begin
                    w_bnc_led = led << 1;
                end
            end else begin
                if (led == 16'h0001) begin
                    w_bnc_led = 16'h0002;
                    w_bnc_dir = DIR_LEFT;
                end else begin
                    w_bnc_led = led >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            running  <= 1'b1;
            r_count  <= '0;
            tick     <= 1'b0;
            led      <= 16'h0001;
            r_dir    <= DIR_LEFT;
            r_mode_q <= 2'd0;
        end else begin
            tick <= w_adv;

            if (r_state == ST_RUN) begin
                r_count <= w_cnt_adv ? '0 : r_count + CNT_W'(1);
            end else if (w_step) begin
                r_count <= '0;
            end

            if (w_pause_edge) begin
                r_state <= (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
                running <= (r_state != ST_RUN);
            end

            if (w_adv) begin
                if (mode != r_mode_q) begin
                    led      <= (mode == 2'd3) ? 16'hFFFF : 16'h0001;
                    r_dir    <= DIR_LEFT;
                    r_mode_q <= mode;
                end else begin
                    case (r_mode_q)
                        2'd0: led <= {led[14:0], led[15]};
                        2'd1: led <= {led[0], led[15:1]};
                        2'd2: begin
                            led   <= w_bnc_led;
                            r_dir <= w_bnc_dir;
                        end
                        default: led <= ~led;
                    endcase
                end
            end
        end
    end

endmodule
